// File: rtl/mem_burst_reader.sv
// ---------------------------------------------------------------------------
// mem_burst_reader
//   Read-side burst initiator for a synchronous memory with a fixed read
//   latency. A request (start address, beats-1) is turned into one sequential
//   read per cycle. Returned words land in a small buffer and leave on a
//   valid/ready stream tagged with a last-beat flag.
//
//   Reads are only issued while the words already in flight plus the words
//   held in the buffer (after this cycle's pop) leave room. Every issued read
//   therefore has a guaranteed slot, and backpressure never drops data.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   burst request handshake
//   req_addr, req_len start address, beat count minus one
//   mem_rd, mem_addr  registered read strobe and address to the memory
//   mem_data          read data, valid rd_latency cycles after mem_rd
//   out_valid/ready   output beat handshake
//   out_data/last     output beat data and final-beat flag
//   busy              burst in progress
// ---------------------------------------------------------------------------
module mem_burst_reader #(
  parameter int addr_width = 16,
  parameter int data_width = 8,
  parameter int len_width  = 8,
  parameter int rd_latency = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [addr_width-1:0] req_addr,
  input  logic [len_width-1:0]  req_len,
  output logic                  mem_rd,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int buf_depth = rd_latency + 2;
  localparam int ptr_width = $clog2(buf_depth);
  // One spare bit so the credit sum can never wrap.
  localparam int cnt_width = $clog2(buf_depth + 1) + 1;

  localparam logic [len_width:0]  beats_one = (len_width + 1)'(1);
  localparam logic [ptr_width-1:0] ptr_last = ptr_width'(buf_depth - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic [addr_width-1:0] addr_cnt;     // next address to issue
  logic [len_width:0]    beats_left;   // reads still to issue
  logic                  mem_last;     // the read on mem_rd is the final one
  logic [rd_latency-1:0] tag_valid;    // one bit per read in the memory pipe
  logic [rd_latency-1:0] tag_last;

  logic [data_width-1:0] buf_data [buf_depth];
  logic                  buf_last [buf_depth];
  logic [ptr_width-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [cnt_width-1:0]  count, inflight, kept, count_nxt;
  logic                  push, push_last, pop, credit_ok;

  function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
    return (p == ptr_last) ? '0 : p + ptr_width'(1);
  endfunction

  // NOTE: every variable gets a value at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    inflight = cnt_width'(mem_rd);
    for (int i = 0; i < rd_latency; i++) begin
      inflight = inflight + cnt_width'(tag_valid[i]);
    end
    pop        = out_valid && out_ready;
    push       = tag_valid[rd_latency-1];
    push_last  = tag_last[rd_latency-1];
    kept       = count - cnt_width'(pop);
    count_nxt  = kept + cnt_width'(push);
    // Popping this cycle frees a slot, so a full pipeline keeps streaming.
    credit_ok  = (inflight + kept) < cnt_width'(buf_depth);
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side below sees the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_last   <= 1'b0;
      addr_cnt   <= '0;
      beats_left <= '0;
      tag_valid  <= '0;
      tag_last   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      // NOTE: the buffer is small and flop-based, and clearing it guarantees
      // nothing from an abandoned burst can ever be presented after reset.
      for (int i = 0; i < buf_depth; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      mem_rd   <= 1'b0;
      mem_last <= 1'b0;

      unique case (state)
        IDLE: begin
          // The buffer is empty here, so the first read goes out on the
          // accepting edge; beats_left then counts the reads after it.
          if (req_valid && req_ready) begin
            mem_rd     <= 1'b1;
            mem_addr   <= req_addr;
            mem_last   <= (req_len == '0);
            addr_cnt   <= req_addr + addr_width'(1);
            beats_left <= {1'b0, req_len};
            state      <= (req_len == '0) ? DRAIN : ISSUE;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            mem_rd     <= 1'b1;
            mem_addr   <= addr_cnt;
            mem_last   <= (beats_left == beats_one);
            addr_cnt   <= addr_cnt + addr_width'(1);  // wraps modulo 2^addr_width
            beats_left <= beats_left - beats_one;
            if (beats_left == beats_one) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Tags follow each read through the memory pipe; a tag leaving the
      // last stage marks the cycle its data is on mem_data.
      tag_valid[0] <= mem_rd;
      tag_last[0]  <= mem_last;
      for (int i = 1; i < rd_latency; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end

      if (push) begin
        buf_data[wr_ptr] <= mem_data;
        buf_last[wr_ptr] <= push_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);

      // Output registers mirror the next head entry. When the buffer is
      // empty after the pop, the head is the word being written right now.
      if (kept == '0) begin
        if (push) begin
          out_data <= mem_data;
          out_last <= push_last;
        end
      end else begin
        out_data <= buf_data[rd_ptr_nxt];
        out_last <= buf_last[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_reader
//   Two instances: dut_a (rd_latency=1) and dut_b (rd_latency=3), each with a
//   memory model returning mem[i] = i[7:0]. A per-cycle table covers the
//   basic and address-wrap bursts; hand-written sequences cover
//   backpressure, long latency, reset mid-burst and a 256-beat burst.
// ---------------------------------------------------------------------------
module tb_mem_burst_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_mem_rd, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [15:0] a_req_addr, a_mem_addr;
  logic [7:0]  a_req_len, a_mem_data, a_out_data;

  logic        b_req_valid, b_req_ready, b_mem_rd, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0] b_req_addr, b_mem_addr;
  logic [7:0]  b_req_len, b_mem_data, b_out_data;

  mem_burst_reader #(.addr_width(16), .data_width(8), .len_width(8), .rd_latency(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr), .req_len(a_req_len),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .busy(a_busy)
  );

  mem_burst_reader #(.addr_width(16), .data_width(8), .len_width(8), .rd_latency(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_len(b_req_len),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy)
  );

  // Memory models: mem[i] = i[7:0]; 0xEE on cycles without a read.
  always @(posedge clk) a_mem_data <= a_mem_rd ? a_mem_addr[7:0] : 8'hEE;

  logic [7:0] b_pipe [3];
  always @(posedge clk) begin
    b_pipe[0] <= b_mem_rd ? b_mem_addr[7:0] : 8'hEE;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_data = b_pipe[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle monitor state, updated by step() at the negedge.
  int         cyc = 0;
  int         a_issued = 0, a_popped = 0, a_max_out = 0;
  logic [8:0] a_beats [$];
  logic [8:0] b_beats [$];
  int         b_rd_cyc [$];
  int         b_ov_cyc [$];

  // Sample the current cycle (inputs already driven), then advance one cycle.
  task automatic step();
    int outst;
    if (a_mem_rd) a_issued++;
    outst = a_issued - a_popped;
    if (outst > a_max_out) a_max_out = outst;
    if (a_out_valid && a_out_ready) begin
      a_beats.push_back({a_out_last, a_out_data});
      a_popped++;
    end
    if (b_mem_rd) b_rd_cyc.push_back(cyc);
    if (b_out_valid && b_out_ready) begin
      b_beats.push_back({b_out_last, b_out_data});
      b_ov_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    logic        req_valid;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic        out_ready;
    logic        x_req_ready;
    logic        x_busy;
    logic        x_mem_rd;
    logic [15:0] x_mem_addr;
    logic        x_out_valid;
    logic [7:0]  x_out_data;
    logic        x_out_last;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [15:0] ra, input logic [7:0] rl,
                              input logic ordy, input logic xrr, input logic xb,
                              input logic xrd, input logic [15:0] xa, input logic xov,
                              input logic [7:0] xd, input logic xl);
    vec_t v;
    v.req_valid = rv;  v.req_addr = ra;  v.req_len = rl;  v.out_ready = ordy;
    v.x_req_ready = xrr;  v.x_busy = xb;  v.x_mem_rd = xrd;  v.x_mem_addr = xa;
    v.x_out_valid = xov;  v.x_out_data = xd;  v.x_out_last = xl;
    return v;
  endfunction

  vec_t vt [16];

  initial begin
    int         stall;
    logic       stall_rd;
    int         t0, bad, rr_bad;
    logic [8:0] e;

    // Rows 0-7: burst at 0x0010 len 3 (accepted at the end of row 0 = edge T).
    // Rows 8-15: burst at 0xFFFE len 3, wrapping to 0x0000.
    //            rv  addr      len   rdy  rr  bsy rd  mem_addr  ov  data   last
    vt[0]  = mk(1, 16'h0010, 8'd3, 1,  1,  0,  0, 16'h0000, 0, 8'h00, 0);
    vt[1]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0010, 0, 8'h00, 0);
    vt[2]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0011, 0, 8'h00, 0);
    vt[3]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0012, 1, 8'h10, 0);
    vt[4]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0013, 1, 8'h11, 0);
    vt[5]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  0, 16'h0000, 1, 8'h12, 0);
    vt[6]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  0, 16'h0000, 1, 8'h13, 1);
    vt[7]  = mk(0, 16'h0000, 8'd0, 1,  1,  0,  0, 16'h0000, 0, 8'h00, 0);
    vt[8]  = mk(1, 16'hFFFE, 8'd3, 1,  1,  0,  0, 16'h0000, 0, 8'h00, 0);
    vt[9]  = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'hFFFE, 0, 8'h00, 0);
    vt[10] = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'hFFFF, 0, 8'h00, 0);
    vt[11] = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0000, 1, 8'hFE, 0);
    vt[12] = mk(0, 16'h0000, 8'd0, 1,  0,  1,  1, 16'h0001, 1, 8'hFF, 0);
    vt[13] = mk(0, 16'h0000, 8'd0, 1,  0,  1,  0, 16'h0000, 1, 8'h00, 0);
    vt[14] = mk(0, 16'h0000, 8'd0, 1,  0,  1,  0, 16'h0000, 1, 8'h01, 1);
    vt[15] = mk(0, 16'h0000, 8'd0, 1,  1,  0,  0, 16'h0000, 0, 8'h00, 0);

    rst = 1'b1;
    a_req_valid = 1'b0;  a_req_addr = '0;  a_req_len = '0;  a_out_ready = 1'b1;
    b_req_valid = 1'b0;  b_req_addr = '0;  b_req_len = '0;  b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- Reset state ----
    check("reset req_ready",  a_req_ready, 1);
    check("reset busy",       a_busy, 0);
    check("reset mem_rd",     a_mem_rd, 0);
    check("reset mem_addr",   a_mem_addr, 0);
    check("reset out_valid",  a_out_valid, 0);
    check("reset out_data",   a_out_data, 0);
    check("reset out_last",   a_out_last, 0);
    check("reset b req_ready", b_req_ready, 1);

    // ---- Tests 1 and 2: cycle-exact table ----
    for (int i = 0; i < 16; i++) begin
      a_req_valid = vt[i].req_valid;
      a_req_addr  = vt[i].req_addr;
      a_req_len   = vt[i].req_len;
      a_out_ready = vt[i].out_ready;
      check($sformatf("row%0d req_ready", i), a_req_ready, vt[i].x_req_ready);
      check($sformatf("row%0d busy", i), a_busy, vt[i].x_busy);
      check($sformatf("row%0d mem_rd", i), a_mem_rd, vt[i].x_mem_rd);
      if (vt[i].x_mem_rd) check($sformatf("row%0d mem_addr", i), a_mem_addr, vt[i].x_mem_addr);
      check($sformatf("row%0d out_valid", i), a_out_valid, vt[i].x_out_valid);
      if (vt[i].x_out_valid) begin
        check($sformatf("row%0d out_data", i), a_out_data, vt[i].x_out_data);
        check($sformatf("row%0d out_last", i), a_out_last, vt[i].x_out_last);
      end
      step();
    end
    a_req_valid = 1'b0;

    // ---- Test 3: backpressure, 16 beats, ready low 10 cycles at beat 3 ----
    a_beats.delete();  a_issued = 0;  a_popped = 0;  a_max_out = 0;
    a_req_valid = 1'b1;  a_req_addr = 16'h0200;  a_req_len = 8'd15;  a_out_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    stall = 0;  stall_rd = 1'b1;
    for (int c = 0; c < 300 && a_beats.size() < 16; c++) begin
      if (a_beats.size() == 3 && stall < 10) begin
        a_out_ready = 1'b0;
        stall++;
        if (stall == 10) stall_rd = a_mem_rd;
      end else begin
        a_out_ready = 1'b1;
      end
      step();
    end
    a_out_ready = 1'b1;
    repeat (5) step();
    check("t3 beat count", a_beats.size(), 16);
    for (int i = 0; i < a_beats.size(); i++) begin
      e = {(i == 15), 8'(i)};
      check($sformatf("t3 beat%0d", i), a_beats[i], e);
    end
    check("t3 outstanding within depth", (a_max_out <= 3), 1);
    check("t3 mem_rd stalled", stall_rd, 0);
    check("t3 reads issued", a_issued, 16);
    check("t3 req_ready back", a_req_ready, 1);

    // ---- Test 4: rd_latency=3, 16 beats, ready held high ----
    b_beats.delete();  b_rd_cyc.delete();  b_ov_cyc.delete();
    b_req_valid = 1'b1;  b_req_addr = 16'h0300;  b_req_len = 8'd15;  b_out_ready = 1'b1;
    t0 = cyc;
    step();
    b_req_valid = 1'b0;
    for (int c = 0; c < 100 && b_beats.size() < 16; c++) step();
    repeat (3) step();
    check("t4 read cycles", b_rd_cyc.size(), 16);
    check("t4 beat count", b_ov_cyc.size(), 16);
    if (b_rd_cyc.size() == 16) begin
      check("t4 first mem_rd", b_rd_cyc[0] - t0, 1);
      check("t4 last mem_rd", b_rd_cyc[15] - t0, 16);
    end
    if (b_ov_cyc.size() == 16) begin
      check("t4 first out_valid", b_ov_cyc[0] - t0, 5);
      check("t4 last out_valid", b_ov_cyc[15] - t0, 20);
    end
    bad = 0;
    for (int i = 0; i < b_beats.size(); i++) begin
      e = {(i == 15), 8'(i)};
      if (b_beats[i] !== e) bad++;
    end
    check("t4 beat order", bad, 0);

    // ---- Test 5: reset mid-burst, then a 2-beat burst ----
    a_beats.delete();
    a_req_valid = 1'b1;  a_req_addr = 16'h0040;  a_req_len = 8'd15;  a_out_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    for (int c = 0; c < 100 && a_beats.size() < 5; c++) step();
    check("t5 reached beat 5", a_beats.size(), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_beats.delete();  a_issued = 0;  a_popped = 0;
    check("t5 out_valid after reset", a_out_valid, 0);
    check("t5 req_ready after reset", a_req_ready, 1);
    a_req_valid = 1'b1;  a_req_addr = 16'h0100;  a_req_len = 8'd1;
    step();
    a_req_valid = 1'b0;
    repeat (30) step();
    check("t5 beat count", a_beats.size(), 2);
    if (a_beats.size() >= 2) begin
      check("t5 beat0", a_beats[0], 9'h000);
      check("t5 beat1", a_beats[1], 9'h101);
    end

    // ---- Test 6: 256 beats, random ready, requests pulsed while busy ----
    a_beats.delete();  a_issued = 0;  a_popped = 0;  a_max_out = 0;  rr_bad = 0;
    a_req_valid = 1'b1;  a_req_addr = 16'h0500;  a_req_len = 8'd255;  a_out_ready = 1'b1;
    step();
    for (int c = 0; c < 3000 && a_beats.size() < 256; c++) begin
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_req_valid = ((c % 17) == 5);
      a_req_addr  = 16'h0900;
      a_req_len   = 8'd0;
      if (a_busy !== 1'b1 || a_req_ready !== 1'b0) rr_bad++;
      step();
    end
    a_req_valid = 1'b0;
    a_out_ready = 1'b1;
    repeat (10) step();
    check("t6 beat count", a_beats.size(), 256);
    bad = 0;
    for (int i = 0; i < a_beats.size(); i++) begin
      e = {(i == 255), 8'(i)};
      if (a_beats[i] !== e) bad++;
    end
    check("t6 beat order and last", bad, 0);
    check("t6 reads issued", a_issued, 256);
    check("t6 req_ready low while busy", rr_bad, 0);
    check("t6 outstanding within depth", (a_max_out <= 3), 1);
    check("t6 idle at end", a_req_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side initiator for the team's parameterised synchronous memories (addr/data, width-parameterised).
- Accepts a burst request (start address, beat count) and issues one sequential read address per cycle to the memory.
- Captures the returned data after a fixed read latency.
- Delivers the data on a valid/ready stream with a last-beat flag, never dropping or duplicating data under backpressure.

Parameters:
- addr_width, 16, memory address width; memory size is 1 << addr_width words.
- data_width, 8, memory data word width.
- len_width, 8, width of the request length field.
- rd_latency, 1, cycles from mem_rd assertion to valid mem_data; legal range 1..8.
- Derived localparam buf_depth = rd_latency + 2, the output buffer depth in words.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, burst request valid.
- req_ready, output, 1, block can accept a request.
- req_addr, input, addr_width, burst start address.
- req_len, input, len_width, beats minus one (0 means 1 beat; max 2^len_width beats).
- mem_rd, output, 1, read strobe, one word per asserted cycle.
- mem_addr, output, addr_width, read address, registered.
- mem_data, input, data_width, read data, valid rd_latency cycles after mem_rd.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts beat.
- out_data, output, data_width, output beat data.
- out_last, output, 1, final beat of burst; qualified by out_valid.
- busy, output, 1, burst in progress.

Behaviour:
- Reset (rst=1 at posedge):
  - All of these go to 0: state=IDLE, mem_rd, mem_addr, out_valid, out_data, out_last, busy.
  - In-flight tracking shift register and buffer are cleared.
  - req_ready is 1 in the first cycle after reset.
- States:
  - IDLE: req_ready=1.
  - ISSUE: addresses remain to be sent.
  - DRAIN: all addresses sent; waiting for in-flight reads and buffered beats to complete.
- IDLE->ISSUE: req_valid && req_ready at edge T.
  - Latch addr_cnt = req_addr and beats_left = req_len + 1.
  - Use len_width+1 bits internally.
- ISSUE:
  - mem_rd=1 with mem_addr=addr_cnt on each cycle the credit permits.
  - Each issue increments addr_cnt and decrements beats_left.
  - Address wraps modulo 2^addr_width, so FFFF is followed by 0000.
  - The last issue moves to DRAIN.
- Credit rule: issue only if inflight + occupancy - pop < buf_depth.
  - pop = out_valid && out_ready in the same cycle.
  - The buffer must never overflow.
- Return path:
  - A valid/last shift register of length rd_latency tracks each issued read.
  - mem_data is written into the buffer on the cycle its tag emerges.
  - The last tag carries out_last.
- Latency:
  - Request accepted at edge T.
  - First mem_rd is high during cycle T+1.
  - Data is captured at edge T+1+rd_latency.
  - out_valid is high from cycle T+2+rd_latency.
- Throughput: with out_ready held at 1, beats are emitted on consecutive cycles with no bubbles, for any rd_latency.
- Output stream rules:
  - out_data and out_last are stable while out_valid && !out_ready.
  - Beats come out in address order.
- DRAIN->IDLE: on the handshake of the out_last beat.
  - req_ready=1 in the next cycle.
  - No back-to-back overlap of bursts.
- busy = (state != IDLE).
- req_valid while busy is ignored (req_ready=0); the request is held by the requester.
- Reset mid-burst:
  - The burst is abandoned.
  - Memory returns still in flight are discarded because their tags were cleared.
  - No stale beat ever appears after reset.
- Simultaneous buffer push and pop in the same cycle is legal at any occupancy, including full.

Test Plan:
1. Defaults, mem[i]=i[7:0], req_addr=0x0010, req_len=3, out_ready=1.
   - mem_addr = 0x10,0x11,0x12,0x13 on cycles T+1..T+4.
   - out_data = 10,11,12,13 on cycles T+3..T+6.
   - out_last only on 13.
   - req_ready returns to 1 at T+7.
2. Wrap: req_addr=0xFFFE, req_len=3.
   - mem_addr sequence FFFE,FFFF,0000,0001.
   - Data order matches.
3. Backpressure: 16-beat burst with out_ready=0 for 10 cycles starting at beat 3.
   - inflight+occupancy never exceeds buf_depth (3 for rd_latency=1).
   - mem_rd stalls.
   - After release, beats 3..15 arrive in order with no loss or duplicates.
4. rd_latency=3, 16-beat burst, out_ready=1.
   - 16 consecutive mem_rd cycles.
   - 16 consecutive out_valid cycles starting at T+5.
5. Reset mid-burst: rst at beat 5 of 16, then new request addr 0x0100 len 1.
   - Only 2 beats (mem[0x100], mem[0x101]) appear.
   - out_last on the second beat.
   - Nothing from the aborted burst appears.
6. req_len=255 with random out_ready.
   - Exactly 256 beats, out_last on beat 256.
   - req_valid pulses during the burst are not accepted.
